mc_frame_scheduler: RTL and testbench

Frame scheduler and command sequencer for one motor-controller channel. It runs the 20 ms servo frame timer and steps the 24-frame modulation state. It presents `State` and `ModInfo` to the pulse modulator and converts the modulator's registered `Pulse` width into the physical PWM pin. Navigation commands enter through a valid/ready handshake and are applied only on modulation-cycle boundaries. A watchdog and an emergency stop force neutral.

---
 rtl/mc_frame_scheduler_if.sv | 26 ++
 rtl/mc_frame_scheduler.sv | 143 ++++++++++++++
 tb/tb_mc_frame_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_frame_scheduler_if.sv
// Command handshake bundle between a navigation source and mc_frame_scheduler.
//   Cmd      : [4:2] duty level 0..7, [1:0] direction (0 fwd, 1 neutral, 2 rev, 3 illegal)
//   CmdValid : command offered by the source
//   CmdReady : scheduler can accept a command
//   CmdErr   : one-cycle pulse after an accepted command with illegal direction
// master = command source, slave = scheduler.
interface mc_frame_scheduler_if;
    logic [4:0] Cmd;
    logic       CmdValid;
    logic       CmdReady;
    logic       CmdErr;

    modport master (
        output Cmd,
        output CmdValid,
        input  CmdReady,
        input  CmdErr
    );

    modport slave (
        input  Cmd,
        input  CmdValid,
        output CmdReady,
        output CmdErr
    );
endinterface

// File: rtl/mc_frame_scheduler.sv
// Frame scheduler / command sequencer for one motor-controller channel.
// Runs the servo frame timer, steps the modulation state, hands State/ModInfo
// to the pulse modulator and turns the returned Pulse width into the PWM pin.
// Commands are buffered one deep and applied only at modulation-cycle wraps;
// a watchdog and an emergency stop force the neutral mode.
// Ports:
//   CLK, RST  : clock, synchronous active-high reset
//   cmd       : command handshake (slave side)
//   Stop      : emergency stop, level-sensitive
//   ModInfo   : mode word to modulator (registered)
//   State     : frame index within the modulation cycle (registered)
//   Pulse     : pulse width from modulator, in clocks
//   PwmOut    : servo pin, high while frame counter < latched pulse width
//   FrameTick : high in the cycle where the frame counter is 0
//   Timeout   : watchdog has forced neutral
module mc_frame_scheduler #(
    parameter int unsigned FRAME_CYCLES   = 2000000,
    parameter int unsigned NUM_STATES     = 24,
    parameter int unsigned NEUTRAL_CYCLES = 150000,
    parameter int unsigned TIMEOUT_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    mc_frame_scheduler_if.slave  cmd,
    input  logic                 Stop,
    output logic [4:0]           ModInfo,
    output logic [4:0]           State,
    input  logic [20:0]          Pulse,
    output logic                 PwmOut,
    output logic                 FrameTick,
    output logic                 Timeout
);

    localparam int unsigned CNT_W  = 21;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 2);

    localparam logic [CNT_W-1:0]  FRAME_LAST  = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0]  NEUTRAL_LEN = CNT_W'(NEUTRAL_CYCLES);
    localparam logic [4:0]        STATE_LAST  = 5'(NUM_STATES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_MAX    = {IDLE_W{1'b1}};
    localparam logic              WDOG_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [4:0]        MOD_NEUTRAL = 5'b00001;

    logic [CNT_W-1:0]  fcnt;
    logic [CNT_W-1:0]  pulse_len;
    logic [4:0]        pend;
    logic              pend_valid;
    logic [IDLE_W-1:0] idle;
    logic              cmd_err_q;
    logic              pwm_q;
    logic              tick_q;

    logic              frame_end;
    logic              cycle_wrap;
    logic [CNT_W-1:0]  fcnt_nx;
    logic [CNT_W-1:0]  pulse_nx;
    logic [IDLE_W-1:0] idle_inc;
    logic              xfer;
    logic              cmd_illegal;

    // Frame timing and next-value computation
    always_comb begin
        frame_end   = (fcnt == FRAME_LAST);
        cycle_wrap  = frame_end && (State == STATE_LAST);
        fcnt_nx     = frame_end ? '0 : fcnt + CNT_W'(1);
        pulse_nx    = pulse_len;
        if (frame_end) begin
            pulse_nx = (Pulse > FRAME_LAST) ? FRAME_LAST : Pulse;
        end
        idle_inc    = idle + IDLE_W'(1);
        xfer        = cmd.CmdValid && cmd.CmdReady;
        cmd_illegal = (cmd.Cmd[1:0] == 2'b11);
    end

    // Outputs are gated by RST so a reset aborts the pulse in the reset cycle itself
    assign cmd.CmdReady = !pend_valid && !Stop && !RST;
    assign cmd.CmdErr   = cmd_err_q;
    assign PwmOut       = pwm_q && !RST;
    assign FrameTick    = tick_q && !RST;

    // Timer, state stepping, command buffer, watchdog and stop handling
    always_ff @(posedge CLK) begin
        if (RST) begin
            fcnt       <= '0;
            pulse_len  <= NEUTRAL_LEN;
            State      <= '0;
            ModInfo    <= MOD_NEUTRAL;
            pend       <= '0;
            pend_valid <= 1'b0;
            idle       <= '0;
            Timeout    <= 1'b0;
            cmd_err_q  <= 1'b0;
            // Preloaded for the first post-reset cycle, which is frame position 0
            pwm_q      <= (NEUTRAL_LEN != '0);
            tick_q     <= 1'b1;
        end else begin
            fcnt      <= fcnt_nx;
            pulse_len <= pulse_nx;
            // Registered pin tracks the counter value it will be shown alongside
            pwm_q     <= (fcnt_nx < pulse_nx);
            tick_q    <= (fcnt_nx == '0);
            cmd_err_q <= 1'b0;

            if (frame_end) begin
                State <= (State == STATE_LAST) ? '0 : State + 5'd1;
            end

            if (Stop) begin
                ModInfo    <= MOD_NEUTRAL;
                pend_valid <= 1'b0;
                idle       <= '0;
            end else begin
                if (cycle_wrap) begin
                    if (pend_valid) begin
                        ModInfo    <= pend;
                        pend_valid <= 1'b0;
                        idle       <= '0;
                        Timeout    <= 1'b0;
                    end else if (WDOG_EN && (idle_inc >= IDLE_LIMIT)) begin
                        ModInfo <= MOD_NEUTRAL;
                        Timeout <= 1'b1;
                        idle    <= IDLE_LIMIT;
                    end else if (idle != IDLE_MAX) begin
                        idle <= idle_inc;
                    end
                end

                // Transfer only happens with the buffer empty, so a command
                // landing on a wrap is held for the following wrap
                if (xfer) begin
                    if (cmd_illegal) begin
                        cmd_err_q <= 1'b1;
                    end else begin
                        pend       <= cmd.Cmd;
                        pend_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_frame_scheduler.sv
// Directed bench for mc_frame_scheduler with a behavioural pulse modulator:
// frames with State < 2*level use 10 (fwd) / 20 (rev) clocks, everything else 15.
module tb_mc_frame_scheduler;

    localparam int unsigned FC = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic [4:0]  mod_info;
    logic [4:0]  state;
    logic [20:0] pulse;
    logic        pwm_out;
    logic        frame_tick;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int w;
    int st;

    mc_frame_scheduler_if cif ();

    mc_frame_scheduler #(
        .FRAME_CYCLES   (FC),
        .NUM_STATES     (24),
        .NEUTRAL_CYCLES (15),
        .TIMEOUT_CYCLES (2)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .cmd       (cif),
        .Stop      (stop),
        .ModInfo   (mod_info),
        .State     (state),
        .Pulse     (pulse),
        .PwmOut    (pwm_out),
        .FrameTick (frame_tick),
        .Timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [20:0] mod_width(input logic [4:0] s, input logic [4:0] mi);
        logic [4:0] lim;
        lim = {1'b0, mi[4:2], 1'b0};
        if (s < lim) begin
            case (mi[1:0])
                2'd0:    return 21'd10;
                2'd2:    return 21'd20;
                default: return 21'd15;
            endcase
        end
        return 21'd15;
    endfunction

    always @(posedge clk) pulse <= mod_width(state, mod_info);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [4:0] s);
        int n;
        n = 0;
        while (state !== s && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("wait_state", 32'(state), 32'(s));
    endtask

    // Starts at a frame-position-0 sample; ends at the next frame's position 0
    task automatic measure(output int wid, output int s);
        int ticks;
        wid   = 0;
        ticks = 0;
        s     = int'(state);
        for (int i = 0; i < int'(FC); i++) begin
            if (pwm_out === 1'b1) wid++;
            if (frame_tick === 1'b1) ticks++;
            @(negedge clk);
        end
        check("tick_count", 32'(ticks), 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        stop         = 1'b0;
        cif.Cmd      = 5'd0;
        cif.CmdValid = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_tick", 32'(frame_tick), 32'd0);
        check("rst_ready", 32'(cif.CmdReady), 32'd0);
        rst = 1'b0;
        #1;
        check("first_tick", 32'(frame_tick), 32'd1);
        check("first_pwm", 32'(pwm_out), 32'd1);
        check("first_state", 32'(state), 32'd0);
        check("first_mod", 32'(mod_info), 32'd1);
        check("first_timeout", 32'(timeout), 32'd0);
        check("first_err", 32'(cif.CmdErr), 32'd0);
        measure(w, st);
        check("frame0_width", 32'(w), 32'd15);
        check("frame0_state", 32'(st), 32'd0);

        // Duty pattern: level 1 fwd
        check("duty_ready_pre", 32'(cif.CmdReady), 32'd1);
        cif.Cmd      = 5'b00100;
        cif.CmdValid = 1'b1;
        @(negedge clk);
        cif.CmdValid = 1'b0;
        check("duty_ready_drop", 32'(cif.CmdReady), 32'd0);
        check("duty_mod_held", 32'(mod_info), 32'd1);
        wait_state(5'd0);
        check("duty_mod_applied", 32'(mod_info), 32'b00100);
        check("duty_ready_back", 32'(cif.CmdReady), 32'd1);
        measure(w, st);
        check("duty_s0_width", 32'(w), 32'd15);
        measure(w, st);
        check("duty_s1_width", 32'(w), 32'd10);
        check("duty_s1_state", 32'(st), 32'd1);
        measure(w, st);
        check("duty_s2_width", 32'(w), 32'd10);
        measure(w, st);
        check("duty_s3_width", 32'(w), 32'd15);

        // Illegal direction
        cif.Cmd      = 5'b11111;
        cif.CmdValid = 1'b1;
        @(negedge clk);
        cif.CmdValid = 1'b0;
        check("err_pulse", 32'(cif.CmdErr), 32'd1);
        check("err_ready", 32'(cif.CmdReady), 32'd1);
        @(negedge clk);
        check("err_pulse_end", 32'(cif.CmdErr), 32'd0);
        check("err_mod_kept", 32'(mod_info), 32'b00100);

        // Watchdog: two command-less wraps
        wait_state(5'd0);
        check("wd1_mod", 32'(mod_info), 32'b00100);
        check("wd1_timeout", 32'(timeout), 32'd0);
        wait_state(5'd1);
        wait_state(5'd0);
        check("wd2_mod", 32'(mod_info), 32'd1);
        check("wd2_timeout", 32'(timeout), 32'd1);

        // Wrap race: transfer in the frame-end cycle of State 23
        wait_state(5'd23);
        repeat (FC - 1) @(negedge clk);
        check("race_ready", 32'(cif.CmdReady), 32'd1);
        cif.Cmd      = 5'b01010;
        cif.CmdValid = 1'b1;
        @(negedge clk);
        cif.CmdValid = 1'b0;
        check("race_state", 32'(state), 32'd0);
        check("race_not_applied", 32'(mod_info), 32'd1);
        check("race_timeout", 32'(timeout), 32'd1);
        check("race_ready_drop", 32'(cif.CmdReady), 32'd0);
        wait_state(5'd1);
        wait_state(5'd0);
        check("race_applied", 32'(mod_info), 32'b01010);
        check("race_timeout_clr", 32'(timeout), 32'd0);

        // Emergency stop with a pending reverse command
        cif.Cmd      = 5'b00110;
        cif.CmdValid = 1'b1;
        @(negedge clk);
        cif.CmdValid = 1'b0;
        check("stop_pend_ready", 32'(cif.CmdReady), 32'd0);
        wait_state(5'd1);
        w = 0;
        for (int i = 0; i < int'(FC); i++) begin
            if (i == 40) stop = 1'b1;
            if (i == 41) begin
                check("stop_mod", 32'(mod_info), 32'd1);
                check("stop_ready", 32'(cif.CmdReady), 32'd0);
            end
            if (pwm_out === 1'b1) w++;
            @(negedge clk);
        end
        check("stop_s1_width", 32'(w), 32'd20);
        measure(w, st);
        check("stop_s2_width", 32'(w), 32'd15);
        check("stop_s2_state", 32'(st), 32'd2);
        stop = 1'b0;
        measure(w, st);
        check("stop_s3_width", 32'(w), 32'd15);
        check("stop_pend_dropped", 32'(cif.CmdReady), 32'd1);
        check("stop_timeout", 32'(timeout), 32'd0);
        wait_state(5'd0);
        check("stop_wrap_mod", 32'(mod_info), 32'd1);
        check("stop_wrap_timeout", 32'(timeout), 32'd0);

        // Mid-frame reset
        wait_state(5'd1);
        repeat (5) @(negedge clk);
        check("mid_pwm_pre", 32'(pwm_out), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_pwm", 32'(pwm_out), 32'd0);
        check("mid_rst_tick", 32'(frame_tick), 32'd0);
        check("mid_rst_ready", 32'(cif.CmdReady), 32'd0);
        @(negedge clk);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_mod", 32'(mod_info), 32'd1);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        check("mid_rst_err", 32'(cif.CmdErr), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rel_tick", 32'(frame_tick), 32'd1);
        check("mid_rel_pwm", 32'(pwm_out), 32'd1);
        check("mid_rel_ready", 32'(cif.CmdReady), 32'd1);
        measure(w, st);
        check("mid_rel_width", 32'(w), 32'd15);
        check("mid_rel_state", 32'(st), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
